// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: stimulus/capture bundle between the sweeper (slave) and its controller or bench (master).
`default_nettype none

interface truth_table_sweeper_if #(
  parameter int N = 4
);
  logic              start;
  logic [N-1:0]      stim;
  logic              y;
  logic [2**N-1:0]   table_q;
  logic              busy;
  logic              done;
  logic [2**N-1:0]   expected;
  logic [N:0]        mismatch_cnt;
  logic              pass;

  modport master (
    output start, y, expected,
    input  stim, table_q, busy, done, mismatch_cnt, pass
  );

  modport slave (
    input  start, y, expected,
    output stim, table_q, busy, done, mismatch_cnt, pass
  );
endinterface

`default_nettype wire

// File: rtl/truth_table_sweeper.sv
// ----------------------------------------------------------------------------
// truth_table_sweeper: walks stim 0..2^N-1 and captures a combinational block's
// truth table; optional golden compare with SWEEP_GOLDEN_CHECK_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module truth_table_sweeper #(
  parameter int N = 4
) (
  input  wire logic             clk,
  input  wire logic             reset,
  truth_table_sweeper_if.slave  bus
);

  localparam logic [N-1:0] c_STIM_LAST = '1;
  localparam logic [N-1:0] c_STIM_ONE  = N'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [N-1:0]      r_stim;
  logic [N-1:0]      w_stim_nxt;
  logic [2**N-1:0]   r_table;
  logic [2**N-1:0]   w_table_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_stim  <= '0;
      r_table <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_stim  <= w_stim_nxt;
      r_table <= w_table_nxt;
    end
  end

  // Terminal check happens before the increment, so stim never wraps and rests at all-ones.
  always_comb begin
    w_state_nxt = r_state;
    w_stim_nxt  = r_stim;
    w_table_nxt = r_table;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_stim_nxt  = '0;
          w_table_nxt = '0;
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: w_state_nxt = S_SAMPLE;
      S_SAMPLE: begin
        w_table_nxt[r_stim] = bus.y;
        if (r_stim == c_STIM_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_stim_nxt  = r_stim + c_STIM_ONE;
          w_state_nxt = S_SETTLE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.stim    = r_stim;
  assign bus.table_q = r_table;
  assign bus.busy    = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
  assign bus.done    = (r_state == S_DONE);

`ifdef SWEEP_GOLDEN_CHECK_EN
  localparam logic [N:0] c_MCNT_MAX = (N+1)'(1) << N;
  localparam logic [N:0] c_MCNT_ONE = (N+1)'(1);

  logic [N:0] r_mcnt;
  logic       r_pass;

  // pass is taken from the final count while in DONE and then held until the next sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcnt <= '0;
      r_pass <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mcnt <= '0;
            r_pass <= 1'b0;
          end
        end
        S_SAMPLE: begin
          if ((bus.y != bus.expected[r_stim]) && (r_mcnt != c_MCNT_MAX)) begin
            r_mcnt <= r_mcnt + c_MCNT_ONE;
          end
        end
        S_DONE:  r_pass <= (r_mcnt == '0);
        default: ;
      endcase
    end
  end

  assign bus.mismatch_cnt = r_mcnt;
  assign bus.pass         = r_pass;
`else
  logic w_unused_expected;
  assign w_unused_expected = ^bus.expected;

  assign bus.mismatch_cnt = '0;
  assign bus.pass         = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: random truth tables swept through an N=4 sweeper plus an N=1 corner case.
`default_nettype none

module tb_truth_table_sweeper;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  logic [15:0] fn;
  logic [15:0] gold;

  truth_table_sweeper_if #(.N(4)) u_if4 ();
  truth_table_sweeper_if #(.N(1)) u_if1 ();

  assign u_if4.y        = fn[u_if4.stim];
  assign u_if4.expected = gold;
  assign u_if1.y        = 1'b1;
  assign u_if1.expected = 2'b11;

  truth_table_sweeper #(.N(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if4)
  );

  truth_table_sweeper #(.N(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Cycle c counts from the cycle after start is accepted; vector k lives in cycles 2k+1..2k+2.
  task automatic sweep(input logic [15:0] f, input logic [15:0] g, input int poke,
                       input int rst_at, input bit chain_in, input bit chain_out);
    int          written;
    logic [31:0] mask;
    logic [15:0] diff;
    logic [31:0] exp_cnt;
    logic        exp_pass;
    fn   = f;
    gold = g;
    diff = f ^ g;
    if (!chain_in) begin
      @(negedge clk);
      u_if4.start = 1'b1;
      @(posedge clk);
      #1;
    end
    for (int c = 1; c <= 34; c++) begin
      u_if4.start = (c == poke) || (chain_out && c == 34);
      reset       = (c == rst_at);
      @(negedge clk);
      written = (c - 1) >> 1;
      if (written > 16) written = 16;
      mask = (32'd1 << written) - 32'd1;
`ifdef SWEEP_GOLDEN_CHECK_EN
      exp_cnt  = 32'($countones(diff & mask[15:0]));
      exp_pass = (c >= 34) && (diff == 16'h0);
`else
      exp_cnt  = 32'd0;
      exp_pass = 1'b0;
`endif
      chk("stim",  u_if4.stim,    (c <= 32) ? ((c - 1) >> 1) : 15);
      chk("busy",  u_if4.busy,    (c <= 32) ? 1 : 0);
      chk("done",  u_if4.done,    (c == 33) ? 1 : 0);
      chk("table", u_if4.table_q, f & mask[15:0]);
      chk("mcnt",  u_if4.mismatch_cnt, exp_cnt);
      chk("pass",  u_if4.pass,    exp_pass);
      @(posedge clk);
      #1;
      if (c == rst_at) begin
        reset       = 1'b0;
        u_if4.start = 1'b0;
        @(negedge clk);
        chk("rst_busy",  u_if4.busy, 0);
        chk("rst_done",  u_if4.done, 0);
        chk("rst_stim",  u_if4.stim, 0);
        chk("rst_table", u_if4.table_q, 0);
        chk("rst_mcnt",  u_if4.mismatch_cnt, 0);
        return;
      end
    end
    u_if4.start = 1'b0;
  endtask

  initial begin
    logic [15:0] f;
    logic [15:0] g;
    n_total     = 0;
    n_bad       = 0;
    fn          = 16'h0;
    gold        = 16'h0;
    u_if4.start = 1'b0;
    u_if1.start = 1'b0;
    reset       = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("r_stim",  u_if4.stim, 0);
    chk("r_table", u_if4.table_q, 0);
    chk("r_busy",  u_if4.busy, 0);
    chk("r_done",  u_if4.done, 0);
    chk("r_mcnt",  u_if4.mismatch_cnt, 0);
    chk("r_pass",  u_if4.pass, 0);
    chk("r1_table", u_if1.table_q, 0);

    // A&B with a stray start mid-sweep, then a start in the DONE cycle.
    sweep(16'hF000, 16'hF000, 10, 0, 1'b0, 1'b0);
    sweep(16'h6996, 16'h6997, 33, 0, 1'b0, 1'b0);
    // Reset mid-sweep, then a clean sweep afterwards.
    sweep(16'($urandom), 16'($urandom), 0, 12, 1'b0, 1'b0);
    sweep(16'hE8E8, 16'hE8E8, 0, 0, 1'b0, 1'b0);
    // Back-to-back: start in the idle cycle right after done.
    sweep(16'h6666, 16'h6666, 0, 0, 1'b0, 1'b1);
    sweep(16'h9999, 16'h0000, 0, 0, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      f = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       g = f;
        1:       g = f ^ (16'd1 << $urandom_range(0, 15));
        default: g = 16'($urandom);
      endcase
      sweep(f, g, int'($urandom_range(0, 33)),
            ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 32)) : 0, 1'b0, 1'b0);
    end

    // N=1 with constant-1 output: stim 0,0,1,1 then done in cycle 5.
    @(negedge clk);
    u_if1.start = 1'b1;
    @(posedge clk);
    #1;
    u_if1.start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 4) chk("n1_stim", u_if1.stim, (c - 1) >> 1);
      chk("n1_busy", u_if1.busy, (c <= 4) ? 1 : 0);
      chk("n1_done", u_if1.done, (c == 5) ? 1 : 0);
      if (c == 5) begin
        chk("n1_table", u_if1.table_q, 2'b11);
        chk("n1_mcnt",  u_if1.mismatch_cnt, 0);
      end
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Hardware stimulus sequencer that feeds a combinational gate-level or operator-level function block. It walks every input combination 0 to 2^N−1 on its `stim` bus, then samples the block's single-bit output after one settle cycle. The captured truth table is exposed as a 2^N-bit vector. This moves the exhaustive truth-table check from a simulation-only bench into synthesizable logic, so a lab board can show the table on LEDs.

## Interface
- `N`, default 4: number of function inputs; legal range 1..6.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle request to begin a sweep; ignored unless the block is idle.
- `stim`  out  N: input vector driven to the function block; `stim[N-1]` is input A (MSB).
- `y`  in  1: function block output, combinational from `stim`.
- `table_q`  out  2^N: captured table; bit k holds `y` observed with `stim == k`.
- `busy`  out  1: high from the cycle after `start` is accepted until `done`, exclusive.
- `done`  out  1: one-cycle pulse when the table is complete.
- `expected`  in  2^N: golden table. Only used with `SWEEP_GOLDEN_CHECK_EN`.
- `mismatch_cnt`  out  N+1: number of bits where `table_q` differs from `expected`. Only used with `SWEEP_GOLDEN_CHECK_EN`.
- `pass`  out  1: high when `mismatch_cnt == 0` after `done`. Only used with `SWEEP_GOLDEN_CHECK_EN`.

## Operation
- FSM states are IDLE, SETTLE, SAMPLE and DONE.
- **IDLE:** `busy`=0.
  - When `start`=1: `stim`←0, `table_q`←0, `mismatch_cnt`←0, `pass`←0, then go to SETTLE.
- **SETTLE:** hold `stim` for one cycle so the combinational function settles, then go to SAMPLE.
- **SAMPLE:** `table_q[stim]`←`y`.
  - If `stim == 2^N−1`, go to DONE.
  - Otherwise `stim`←`stim+1` and go to SETTLE.
- **DONE:** `done`=1 for exactly this cycle, then go to IDLE.
- Between sweeps, `table_q` and `stim` hold their last values. `stim` rests at 2^N−1.
- `start` is ignored in SETTLE, SAMPLE and DONE.
  - A `start` in the DONE cycle is also ignored.
  - A new sweep needs `start` while in IDLE.
- `stim` is a plain N-bit counter. It never wraps inside a sweep, because the terminal check precedes the increment.
- `y` is treated as 0/1. X/Z handling is a bench concern.

## Timing
- Reset values: state=IDLE, `stim`=0, `table_q`=0, `busy`=0, `done`=0, `mismatch_cnt`=0, `pass`=0.
- Reset has priority over everything, including mid-sweep. The partial table is discarded and cleared.
- Cycle 0 is the cycle in which `start` is sampled in IDLE.
  - Vector k is driven from cycle 2k+1.
  - Vector k is sampled at the end of cycle 2k+2.
  - `done` is high in cycle 2^(N+1)+1; for N=4 that is cycle 33.
- `busy` is high for cycles 1..2^(N+1). `busy` and `done` are never both high.
- `table_q` is complete and stable in the `done` cycle.
- Each bit of `table_q` is written exactly once per sweep.

## Configuration
- Macro: `SWEEP_GOLDEN_CHECK_EN`.
- **Defined:** in each SAMPLE cycle, `mismatch_cnt` increments when `y != expected[stim]`. The count saturates at 2^N, which its N+1-bit width can hold.
  - `pass` is registered in the DONE cycle as (`mismatch_cnt` == 0), using the final count.
  - `pass` holds until the next accepted `start` or `reset`.
- **Undefined:** `expected` is unused. `mismatch_cnt` and `pass` are tied to 0. The FSM and timing are identical.

## Test plan
- **Majority sweep:** N=3, `y`=maj(A,B,C), pulse `start` → `done` at cycle 17, `table_q`=8'b1110_1000. With the macro and `expected`=8'b1110_1000: `mismatch_cnt`=0, `pass`=1.
- **Injected fault:** N=3, `expected`=8'b1110_1001 with the same DUT, macro defined → `mismatch_cnt`=1, `pass`=0 after `done`.
- **Start while busy:** N=4, `y`=A&B. Re-pulse `start` at cycle 10 → the sweep is unaffected, `done` only at cycle 33, `table_q`=16'hF000.
- **Reset mid-sweep:** N=4. Assert `reset` at cycle 12 → the next cycle shows `busy`=0, `stim`=0, `table_q`=0. A fresh `start` produces the full table with `done` 33 cycles later.
- **Back-to-back:** N=2, `y`=A^B. Run two sweeps with `start` on the cycle after `done` → both give `table_q`=4'b0110. The second sweep clears the table on acceptance.
- **Constant output:** N=1, `y`=1 → `done` at cycle 5, `table_q`=2'b11. `stim` sequence over cycles 1..4 is 0,0,1,1.
